// File: rtl/memaccess_ctrl.sv
// LC-3 memory-access stage: sequences direct and indirect loads/stores against a
// variable-latency data memory, with a per-phase ack timeout.
module memaccess_ctrl #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              MControl,
  input  logic [DATA_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MData,
  output logic              DMem_en,
  output logic              DMem_rd,
  output logic [DATA_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  input  logic              DMem_ack,
  input  logic [DATA_W-1:0] DMem_out,
  output logic [DATA_W-1:0] memout,
  output logic              completedata,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IND  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter value in the last cycle a phase may wait before it is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_reg;
  logic              write_reg;
  logic              ind_reg;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] ptr_reg;
  logic [7:0]        cnt_reg;
  logic [DATA_W-1:0] memout_reg;
  logic              err_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      write_reg  <= 1'b0;
      ind_reg    <= 1'b0;
      addr_reg   <= '0;
      data_reg   <= '0;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      memout_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            write_reg <= req_write;
            ind_reg   <= MControl;
            addr_reg  <= MAddr;
            data_reg  <= MData;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= MControl ? S_IND : S_ACC;
          end
        end
        S_IND: begin
          // Ack takes priority over an expiring timeout in the same cycle.
          if (DMem_ack) begin
            ptr_reg   <= DMem_out;
            cnt_reg   <= '0;
            state_reg <= S_ACC;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        S_ACC: begin
          if (DMem_ack) begin
            if (!write_reg) memout_reg <= DMem_out;
            state_reg <= S_DONE;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Port outputs are pure decodes of registered state; no input reaches an output.
  assign req_ready    = (state_reg == S_IDLE);
  assign DMem_en      = (state_reg == S_IND) || (state_reg == S_ACC);
  assign completedata = (state_reg == S_DONE);
  assign DMem_rd      = !((state_reg == S_ACC) && write_reg);
  assign DMem_din     = ((state_reg == S_ACC) && write_reg) ? data_reg : '0;
  assign memout       = memout_reg;
  assign err          = err_reg;

  always_comb begin
    DMem_addr = '0;
    if (state_reg == S_IND)      DMem_addr = addr_reg;
    else if (state_reg == S_ACC) DMem_addr = ind_reg ? ptr_reg : addr_reg;
  end

endmodule

// File: tb/tb_memaccess_ctrl.sv
// Randomized bench for memaccess_ctrl: a behavioural memory answers each access
// after a chosen number of wait cycles; results and latency are predicted per request.
module tb_memaccess_ctrl;

  localparam int W  = 16;
  localparam int TO = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic         MControl = 1'b0;
  logic [W-1:0] MAddr = '0;
  logic [W-1:0] MData = '0;
  logic         DMem_en;
  logic         DMem_rd;
  logic [W-1:0] DMem_addr;
  logic [W-1:0] DMem_din;
  logic         DMem_ack = 1'b0;
  logic [W-1:0] DMem_out = '0;
  logic [W-1:0] memout;
  logic         completedata;
  logic         err;

  memaccess_ctrl #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .MControl(MControl),
    .MAddr(MAddr), .MData(MData),
    .DMem_en(DMem_en), .DMem_rd(DMem_rd),
    .DMem_addr(DMem_addr), .DMem_din(DMem_din),
    .DMem_ack(DMem_ack), .DMem_out(DMem_out),
    .memout(memout), .completedata(completedata), .err(err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] mem [int];
  logic [W-1:0] exp_memout = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Unwritten locations hold a fixed function of their address.
  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 16'h5A3C;
  endfunction

  // One request; w1 = wait cycles of the first phase, w2 of the data phase when
  // indirect. A wait >= TO means the memory never answers that phase.
  task automatic do_txn(input bit wr, input bit ind, input logic [W-1:0] a,
                        input logic [W-1:0] d, input int w1, input int w2);
    int waits [2];
    int nph, lat, cyc, p, k, g;
    bit exp_err, done, data_ph;
    logic [W-1:0] ptr, tgt, e_addr, e_din;
    logic e_rd;
    waits[0] = w1;
    waits[1] = w2;
    nph = ind ? 2 : 1;
    lat = 1;
    exp_err = 1'b0;
    for (int i = 0; i < nph; i++) begin
      if (waits[i] >= TO) begin
        lat += TO;
        exp_err = 1'b1;
        break;
      end
      lat += waits[i] + 1;
    end

    @(negedge clock);
    g = 0;
    while (!req_ready && g < 10) begin
      @(negedge clock);
      g++;
    end
    check_eq("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; MControl = ind; MAddr = a; MData = d;
    @(negedge clock);
    req_valid = 1'b0;
    req_write = 1'($urandom); MControl = 1'($urandom);
    MAddr = 16'($urandom); MData = 16'($urandom);
    check_eq("ready_busy", req_ready, 0);
    check_eq("err_cleared", err, 0);

    cyc = 1; p = 0; k = 0; done = 1'b0; ptr = '0;
    while (!done && cyc < 40) begin
      if (completedata) begin
        done = 1'b1;
        check_eq("latency", cyc, lat);
        check_eq("err", err, exp_err);
        check_eq("memout", memout, exp_memout);
        check_eq("en_done", DMem_en, 0);
        check_eq("ready_done", req_ready, 0);
        DMem_ack = 1'($urandom);
        DMem_out = 16'($urandom);
      end else begin
        check_eq("en_active", DMem_en, 1);
        data_ph = (p == nph - 1);
        tgt     = ind ? ptr : a;
        e_addr  = data_ph ? tgt : a;
        e_rd    = data_ph ? !wr : 1'b1;
        e_din   = (data_ph && wr) ? d : '0;
        check_eq("addr", DMem_addr, e_addr);
        check_eq("rd", DMem_rd, e_rd);
        check_eq("din", DMem_din, e_din);
        if (p < nph && k == waits[p]) begin
          DMem_ack = 1'b1;
          if (!data_ph) begin
            DMem_out = mem_rd(a);
            ptr = DMem_out;
          end else if (wr) begin
            mem[int'(tgt)] = d;
            DMem_out = 16'($urandom);
          end else begin
            DMem_out = mem_rd(tgt);
            exp_memout = DMem_out;
          end
          p++;
          k = 0;
        end else begin
          DMem_ack = 1'b0;
          DMem_out = 16'($urandom);
          k++;
        end
        @(negedge clock);
        cyc++;
      end
    end
    check_eq("done_seen", done, 1);
    @(negedge clock);
    DMem_ack = 1'b0;
    check_eq("done_one_cycle", completedata, 0);
    check_eq("ready_after", req_ready, 1);
    $display("txn wr=%0d ind=%0d addr=%h data=%h waits=%0d/%0d lat=%0d err=%0d memout=%h",
             wr, ind, a, d, w1, w2, cyc, err, memout);
  endtask

  // Idle cycles with stray acks, which must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      DMem_ack = 1'($urandom);
      DMem_out = 16'($urandom);
      @(negedge clock);
      check_eq("idle_no_done", completedata, 0);
    end
    DMem_ack = 1'b0;
    check_eq("idle_memout", memout, exp_memout);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 2);
    if (r < 8) return TO - 1;
    if (r == 8) return TO;
    return 255;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_en", DMem_en, 0);
    check_eq("rst_rd", DMem_rd, 1);
    check_eq("rst_addr", DMem_addr, 0);
    check_eq("rst_din", DMem_din, 0);
    check_eq("rst_memout", memout, 0);
    check_eq("rst_done", completedata, 0);
    check_eq("rst_err", err, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    mem[16'h3000] = 16'hBEEF;
    mem[16'h4000] = 16'h5000;
    mem[16'h5000] = 16'hA5A5;
    mem[16'h4002] = 16'h6000;

    do_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 0);
    check_eq("ld_beef", memout, 16'hBEEF);
    do_txn(1'b1, 1'b0, 16'h3010, 16'h1234, 3, 0);
    check_eq("st_keeps_memout", memout, 16'hBEEF);
    do_txn(1'b0, 1'b1, 16'h4000, 16'h0000, 0, 0);
    check_eq("ldi_a5a5", memout, 16'hA5A5);
    do_txn(1'b1, 1'b1, 16'h4002, 16'h00FF, 0, 0);
    do_txn(1'b0, 1'b0, 16'h6000, 16'h0000, 0, 0);
    check_eq("sti_result", memout, 16'h00FF);
    do_txn(1'b0, 1'b0, 16'h3020, 16'h0000, 255, 0);
    check_eq("to_memout", memout, 16'h00FF);
    do_txn(1'b0, 1'b0, 16'h3010, 16'h0000, TO - 1, 0);
    check_eq("ack_wins", memout, 16'h1234);
    do_txn(1'b0, 1'b1, 16'h4000, 16'h0000, 255, 0);
    idle_cycles(3);

    // Reset in the middle of a data access.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; MControl = 1'b0; MAddr = 16'h3000;
    @(negedge clock);
    req_valid = 1'b0;
    DMem_ack = 1'b0;
    @(negedge clock);
    check_eq("pre_rst_en", DMem_en, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_en", DMem_en, 0);
    check_eq("arst_ready", req_ready, 1);
    check_eq("arst_done", completedata, 0);
    check_eq("arst_memout", memout, 0);
    check_eq("arst_addr", DMem_addr, 0);
    exp_memout = '0;
    @(negedge clock);
    reset = 1'b1;
    idle_cycles(2);
    do_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 1, 0);
    check_eq("post_rst_ld", memout, 16'hBEEF);

    for (int t = 0; t < 60; t++) begin
      do_txn(1'($urandom), 1'($urandom), 16'h3000 | 16'($urandom_range(0, 15)),
             16'($urandom), pick_wait(), pick_wait());
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
